// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// State encodings sit beside the ROM width used by the instruction ROM.
package program_loader_pkg;

  localparam int ROM_ADDRESS_BITWIDTH = 10;

  typedef enum logic [1:0] {
    LOADER_STATE_SIZE  = 2'd0,
    LOADER_STATE_DATA  = 2'd1,
    LOADER_STATE_DONE  = 2'd2,
    LOADER_STATE_ERROR = 2'd3
  } loader_state_t;

  function automatic logic [32:0] word_capacity(input int aw);
    return 33'd1 << (aw - 2);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream valid/ready handshake feeding the program loader.
// The host side is the master; the loader is the slave.
interface program_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word.
// The word is presented combinationally alongside the 4th byte.
module program_loader_word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  idx;
  logic [23:0] part;

  assign word          = {byte_data, part};
  assign word_complete = byte_valid && !clear && (idx == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx  <= 2'd0;
      part <= 24'd0;
    end else if (clear) begin
      idx  <= 2'd0;
    end else if (byte_valid) begin
      idx  <= idx + 2'd1;
      part <= {byte_data, part[23:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header word count, then payload words written to ROM.
// Holds the CPU in reset until the final word has been written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = ROM_ADDRESS_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  program_loader_if.slave             stream,
  output logic                        rom_wren,
  output logic [ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                 rom_write_data,
  output logic                        cpu_reset_n,
  output logic                        done,
  output logic                        error
);

  localparam logic [32:0] CAPACITY = word_capacity(ADDRESS_BITWIDTH);

  loader_state_t state_q;
  loader_state_t state_d;

  logic [31:0] n_q;
  logic [31:0] wcnt_q;
  logic [31:0] word;
  logic        complete;
  logic        fire;
  logic        last_word;

  assign stream.in_ready = (state_q == LOADER_STATE_SIZE) ||
                           (state_q == LOADER_STATE_DATA);
  assign fire      = stream.in_valid && stream.in_ready;
  assign last_word = (wcnt_q == n_q - 32'd1);

  program_loader_word_assembler u_asm (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (!stream.in_ready),
    .byte_valid    (fire),
    .byte_data     (stream.in_data),
    .word          (word),
    .word_complete (complete)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOADER_STATE_SIZE: begin
        if (complete) begin
          if (word == 32'd0)
            state_d = LOADER_STATE_DONE;
          else if ({1'b0, word} > CAPACITY)
            state_d = LOADER_STATE_ERROR;
          else
            state_d = LOADER_STATE_DATA;
        end
      end
      LOADER_STATE_DATA: begin
        if (complete && last_word)
          state_d = LOADER_STATE_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOADER_STATE_SIZE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q            <= 32'd0;
      wcnt_q         <= 32'd0;
      rom_wren       <= 1'b0;
      rom_address    <= '0;
      rom_write_data <= 32'd0;
      cpu_reset_n    <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      rom_wren <= 1'b0;
      // Release the core a cycle after done so the last write lands first
      cpu_reset_n <= done;
      done        <= (state_d == LOADER_STATE_DONE);
      error       <= (state_d == LOADER_STATE_ERROR);
      if (state_q == LOADER_STATE_SIZE && complete) begin
        n_q    <= word;
        wcnt_q <= 32'd0;
      end
      if (state_q == LOADER_STATE_DATA && complete) begin
        rom_wren       <= 1'b1;
        rom_address    <= ADDRESS_BITWIDTH'({wcnt_q, 2'b00});
        rom_write_data <= word;
        wcnt_q         <= wcnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader.
// Expected writes are derived by parsing the byte stream in the bench.
module tb_program_loader;

  localparam int AW = 10;
  localparam longint CAP = 64'd1 << (AW - 2);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rom_wren;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_write_data;
  logic          cpu_reset_n;
  logic          done;
  logic          error;

  program_loader_if lif ();

  program_loader #(.ADDRESS_BITWIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stream         (lif),
    .rom_wren       (rom_wren),
    .rom_address    (rom_address),
    .rom_write_data (rom_write_data),
    .cpu_reset_n    (cpu_reset_n),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  img[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc = -1;
  int          cpu_cyc = -1;
  int          last_hs = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rom_wren) begin
        wr_addr.push_back(int'(rom_address));
        wr_data.push_back(rom_write_data);
        wr_cyc.push_back(cyc);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (cpu_reset_n && cpu_cyc < 0) cpu_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc = -1;
    cpu_cyc  = -1;
  endtask

  task automatic do_reset();
    lif.in_valid = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear_mon();
    reset_n = 1'b1;
  endtask

  task automatic build_image(input logic [31:0] n, input int nw);
    logic [31:0] w;
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back(8'(n >> (8 * i)));
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      for (int i = 0; i < 4; i++) img.push_back(8'(w >> (8 * i)));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int t;
    if (gap > 0) begin
      lif.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    lif.in_valid = 1'b1;
    lif.in_data  = b;
    t = 0;
    while (1) begin
      @(negedge clk);
      rdy = lif.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 50) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    last_hs = cyc;
  endtask

  task automatic stream_image(input int gap_max);
    foreach (img[i]) send_byte(img[i], $urandom_range(0, gap_max));
    lif.in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) check("end_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_result(input string tg);
    logic [31:0] n;
    logic [31:0] w;
    n = {img[3], img[2], img[1], img[0]};
    if (longint'(n) > CAP) begin
      check({tg, "_err"}, error, 1);
      check({tg, "_err_rdy"}, lif.in_ready, 0);
      check({tg, "_err_nwr"}, wr_addr.size(), 0);
      check({tg, "_err_cpu"}, cpu_reset_n, 0);
      check({tg, "_err_done"}, done, 0);
    end else begin
      check({tg, "_nwr"}, wr_addr.size(), n);
      for (int k = 0; k < int'(n) && k < wr_addr.size(); k++) begin
        w = {img[4*k+7], img[4*k+6], img[4*k+5], img[4*k+4]};
        check({tg, "_addr"}, wr_addr[k], (4 * k) % (1 << AW));
        check({tg, "_data"}, wr_data[k], w);
      end
      check({tg, "_done"}, done, 1);
      check({tg, "_noerr"}, error, 0);
      check({tg, "_done_cyc"}, done_cyc, last_hs);
      if (n > 0 && wr_cyc.size() > 0)
        check({tg, "_lastwr_cyc"}, wr_cyc[wr_cyc.size()-1], last_hs);
      check({tg, "_cpu_cyc"}, cpu_cyc, done_cyc + 1);
      check({tg, "_rdy0"}, lif.in_ready, 0);
    end
  endtask

  task automatic send_ignored(input string tg, input int cnt);
    int nw;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic dn, cr, er;
    nw = wr_addr.size();
    a  = rom_address;
    d  = rom_write_data;
    dn = done;
    cr = cpu_reset_n;
    er = error;
    for (int i = 0; i < cnt; i++) begin
      lif.in_valid = 1'b1;
      lif.in_data  = 8'($urandom);
      @(negedge clk);
      check({tg, "_ign_rdy"}, lif.in_ready, 0);
      @(posedge clk);
      #1;
    end
    lif.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tg, "_ign_nwr"}, wr_addr.size(), nw);
    check({tg, "_ign_addr"}, rom_address, a);
    check({tg, "_ign_data"}, rom_write_data, d);
    check({tg, "_ign_state"}, {dn, cr, er}, {done, cpu_reset_n, error});
  endtask

  initial begin
    logic [31:0] n;
    lif.in_valid = 1'b0;
    lif.in_data  = 8'h00;
    reset_n      = 1'b0;
    #12;
    check("rst_ready", lif.in_ready, 1);
    check("rst_outs", {rom_wren, cpu_reset_n, done, error}, 4'b0000);
    check("rst_addr", rom_address, 0);
    check("rst_data", rom_write_data, 0);

    // Two-word image, no gaps
    do_reset();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00};
    stream_image(0);
    wait_end();
    check_result("two");
    if (wr_cyc.size() == 2) check("two_b2b", wr_cyc[1] - wr_cyc[0], 4);
    send_ignored("two", 16);

    // Same stream with 3-cycle gaps between bytes
    do_reset();
    foreach (img[i]) send_byte(img[i], 3);
    lif.in_valid = 1'b0;
    wait_end();
    check_result("gap");

    // Empty image
    do_reset();
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    stream_image(0);
    wait_end();
    check_result("zero");

    // Capacity + 1 is rejected
    do_reset();
    img = '{8'h01, 8'h01, 8'h00, 8'h00};
    stream_image(0);
    wait_end();
    check_result("over");
    send_ignored("over", 8);
    check("over_cpu_hold", cpu_reset_n, 0);

    // Exactly capacity-sized header is accepted into DATA
    do_reset();
    img = '{8'h00, 8'h01, 8'h00, 8'h00};
    stream_image(0);
    repeat (2) @(negedge clk);
    check("cap_ok_rdy", lif.in_ready, 1);
    check("cap_ok_err", error, 0);

    // Reset mid-load, then a fresh one-word image
    do_reset();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00};
    stream_image(0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_data", rom_write_data, 0);
    check("midrst_rdy", lif.in_ready, 1);
    check("midrst_cpu", cpu_reset_n, 0);
    @(posedge clk);
    #1 clear_mon();
    reset_n = 1'b1;
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    stream_image(1);
    wait_end();
    check_result("midrst");

    // Randomized images
    for (int it = 0; it < 12; it++) begin
      do_reset();
      if ($urandom_range(0, 5) == 0) begin
        n = 32'(CAP) + 32'($urandom_range(1, 100000));
        build_image(n, 0);
      end else begin
        n = $urandom_range(0, 6);
        build_image(n, int'(n));
      end
      stream_image($urandom_range(0, 2));
      wait_end();
      check_result($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
